// File: rtl/hard_reset_receiver_if.sv
// Bundle of PHY receive indications, TCPM register writes and PE handshake
// around the hard-reset receiver.
interface hard_reset_receiver_if;
   logic        PHY_HardReset_Rcvd;
   logic        PHY_CableReset_Rcvd;
   logic [7:0]  iRECEIVE_DETECT;
   logic        RECEIVE_DETECT_WE;
   logic [15:0] iAlert_Clear;
   logic        PE_HR_Complete;
   logic [15:0] ALERT;
   logic [7:0]  oRECEIVE_DETECT;
   logic [7:0]  oRECEIVE_BYTE_COUNT;
   logic        PRL_Reset_Layer;
   logic        PE_Hard_Reset_Ind;
   logic        oReset_Type;
   logic        oHR_Busy;
   logic        oHR_Timeout;

   // Driver side: PHY, TCPM and PE
   modport master (
      output PHY_HardReset_Rcvd, PHY_CableReset_Rcvd, iRECEIVE_DETECT,
             RECEIVE_DETECT_WE, iAlert_Clear, PE_HR_Complete,
      input  ALERT, oRECEIVE_DETECT, oRECEIVE_BYTE_COUNT, PRL_Reset_Layer,
             PE_Hard_Reset_Ind, oReset_Type, oHR_Busy, oHR_Timeout
   );

   // Receiver side
   modport slave (
      input  PHY_HardReset_Rcvd, PHY_CableReset_Rcvd, iRECEIVE_DETECT,
             RECEIVE_DETECT_WE, iAlert_Clear, PE_HR_Complete,
      output ALERT, oRECEIVE_DETECT, oRECEIVE_BYTE_COUNT, PRL_Reset_Layer,
             PE_Hard_Reset_Ind, oReset_Type, oHR_Busy, oHR_Timeout
   );
endinterface

// File: rtl/hard_reset_receiver.sv
// Hard Reset / Cable Reset receive sequencer: resets the protocol layer,
// indicates to the PE, raises ALERT.ReceivedHardReset and waits for PE
// completion with a timeout.
//
// state       | meaning
// ------------+------------------------------------------------------
// IDLE        | one cycle after reset release
// WAIT_DETECT | armed; accepts RECEIVE_DETECT writes and detect pulses
// RESET_LAYER | pulse PRL_Reset_Layer, clear RECEIVE_DETECT/byte count
// INDICATE    | pulse PE_Hard_Reset_Ind, set ALERT[3] on exit
// WAIT_PE     | wait for PE_HR_Complete or timeout
// COMPLETE    | one cycle wrap-up, back to WAIT_DETECT
module hard_reset_receiver #(
   parameter int PE_TIMEOUT = 1000,
   parameter int CNT_W      = 16
) (
   input logic                CLK,
   input logic                reset,
   hard_reset_receiver_if.slave bus
);

   localparam logic [5:0] S_IDLE        = 6'b000001;
   localparam logic [5:0] S_WAIT_DETECT = 6'b000010;
   localparam logic [5:0] S_RESET_LAYER = 6'b000100;
   localparam logic [5:0] S_INDICATE    = 6'b001000;
   localparam logic [5:0] S_WAIT_PE     = 6'b010000;
   localparam logic [5:0] S_COMPLETE    = 6'b100000;
   localparam logic [5:0] S_BUSY_MASK   = S_RESET_LAYER | S_INDICATE | S_WAIT_PE | S_COMPLETE;

   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(PE_TIMEOUT - 1);

   logic [5:0]       r_state;
   logic [5:0]       w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [15:0]      r_alert;
   logic [7:0]       r_rx_detect;
   logic [7:0]       r_byte_count;
   logic             r_prl_reset;
   logic             r_pe_ind;
   logic             r_reset_type;
   logic             r_busy;
   logic             r_timeout;

   logic             w_cr;
   logic             w_hr;
   logic             w_detect;
   logic             w_timeout_hit;
   logic [15:0]      w_alert_set;

   // Detect qualification uses the register value before any same-cycle write
   assign w_cr          = bus.PHY_CableReset_Rcvd & r_rx_detect[6];
   assign w_hr          = bus.PHY_HardReset_Rcvd & r_rx_detect[5];
   assign w_detect      = w_cr | w_hr;
   assign w_timeout_hit = (r_cnt == C_LAST);
   assign w_alert_set   = (r_state == S_INDICATE) ? 16'h0008 : 16'h0000;

   // Next-state decode
   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE:        w_next = S_WAIT_DETECT;
         S_WAIT_DETECT: w_next = w_detect ? S_RESET_LAYER : S_WAIT_DETECT;
         S_RESET_LAYER: w_next = S_INDICATE;
         S_INDICATE:    w_next = S_WAIT_PE;
         S_WAIT_PE:     w_next = (bus.PE_HR_Complete || w_timeout_hit) ? S_COMPLETE : S_WAIT_PE;
         S_COMPLETE:    w_next = S_WAIT_DETECT;
         default:       w_next = S_IDLE;
      endcase
   end

   // State, registered outputs, counter and register file
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_alert      <= '0;
         r_rx_detect  <= '0;
         r_byte_count <= '0;
         r_prl_reset  <= 1'b0;
         r_pe_ind     <= 1'b0;
         r_reset_type <= 1'b0;
         r_busy       <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_prl_reset <= (w_next == S_RESET_LAYER);
         r_pe_ind    <= (w_next == S_INDICATE);
         r_busy      <= |(w_next & S_BUSY_MASK);
         // Set wins over a same-cycle clear of bit 3
         r_alert     <= (r_alert & ~bus.iAlert_Clear) | w_alert_set;

         if (r_state == S_WAIT_DETECT && w_detect) begin
            r_reset_type <= w_cr;
            r_timeout    <= 1'b0;
         end

         // Completion beats timeout when both occur together
         if (r_state == S_WAIT_PE && !bus.PE_HR_Complete && w_timeout_hit)
            r_timeout <= 1'b1;

         if (r_state == S_RESET_LAYER) begin
            r_rx_detect  <= '0;
            r_byte_count <= '0;
         end else if (r_state == S_WAIT_DETECT && bus.RECEIVE_DETECT_WE) begin
            r_rx_detect  <= bus.iRECEIVE_DETECT;
         end

         // Counter exits at C_LAST so it never wraps; holds in other states
         if (r_state == S_RESET_LAYER || r_state == S_COMPLETE)
            r_cnt <= '0;
         else if (r_state == S_WAIT_PE)
            r_cnt <= r_cnt + 1'b1;
      end
   end

   assign bus.ALERT               = r_alert;
   assign bus.oRECEIVE_DETECT     = r_rx_detect;
   assign bus.oRECEIVE_BYTE_COUNT = r_byte_count;
   assign bus.PRL_Reset_Layer     = r_prl_reset;
   assign bus.PE_Hard_Reset_Ind   = r_pe_ind;
   assign bus.oReset_Type         = r_reset_type;
   assign bus.oHR_Busy            = r_busy;
   assign bus.oHR_Timeout         = r_timeout;

endmodule
